// File: rtl/c2c_amo_unit_if.sv
// Shared pipeline constants and the c2c_data request bus used between the
// core LSU, the AMO sequencer and the data cache.
package pipeline;
    parameter int unsigned XLEN = 32;
endpackage

interface c2c_data;
    logic                       re;
    logic                       we;
    logic [pipeline::XLEN-1:0]  addr;
    logic [3:0]                 sel;
    logic [pipeline::XLEN-1:0]  data_w;
    logic                       atomic;
    logic [4:0]                 amo_op;
    logic                       ack;
    logic [pipeline::XLEN-1:0]  data_r;

    modport master (
        output re, we, addr, sel, data_w, atomic, amo_op,
        input  ack, data_r
    );

    modport slave (
        input  re, we, addr, sel, data_w, atomic, amo_op,
        output ack, data_r
    );
endinterface

// File: rtl/c2c_amo_unit.sv
// Atomic-memory-operation sequencer: passes plain loads/stores through to the
// cache and expands RV32A LR/SC/AMO requests into read / modify / write steps.
module c2c_amo_unit (
    input logic      clk,
    input logic      rst,
    c2c_data.slave   core,
    c2c_data.master  mem
);
    localparam int unsigned XLEN = pipeline::XLEN;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AMO_RD = 3'd1,
        AMO_WR = 3'd2,
        SC_WR  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_n;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   src_r;
    logic [4:0]        op_r;
    logic [XLEN-1:0]   old_r;
    logic [XLEN-1:0]   result_r;
    logic              resv_valid_r;
    logic [XLEN-3:0]   resv_addr_r;
    logic              atomic_req_s;
    logic              sc_hit_s;

    function automatic logic op_defined(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: op_defined = 1'b1;
            default:                          op_defined = 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] amo_alu(input logic [4:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        case (op)
            OP_SWAP: amo_alu = b;
            OP_ADD:  amo_alu = a + b;
            OP_XOR:  amo_alu = a ^ b;
            OP_AND:  amo_alu = a & b;
            OP_OR:   amo_alu = a | b;
            OP_MIN:  amo_alu = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  amo_alu = ($signed(a) > $signed(b)) ? a : b;
            OP_MINU: amo_alu = (a < b) ? a : b;
            OP_MAXU: amo_alu = (a > b) ? a : b;
            default: amo_alu = a;
        endcase
    endfunction

    assign atomic_req_s = core.atomic && (core.re || core.we);
    assign sc_hit_s     = resv_valid_r && (core.addr[XLEN-1:2] == resv_addr_r);

    // Next-state selection and drive of both bus ports.
    always_comb begin
        state_n      = state_r;
        mem.re       = 1'b0;
        mem.we       = 1'b0;
        mem.addr     = addr_r;
        mem.sel      = 4'hF;
        mem.data_w   = {XLEN{1'b0}};
        mem.atomic   = 1'b0;
        mem.amo_op   = 5'b00000;
        core.ack     = 1'b0;
        core.data_r  = {XLEN{1'b0}};
        case (state_r)
            IDLE: begin
                if (core.atomic) begin
                    if (atomic_req_s) begin
                        if (!op_defined(core.amo_op)) begin
                            state_n = RESP;
                        end else if (core.amo_op == OP_SC) begin
                            state_n = sc_hit_s ? SC_WR : RESP;
                        end else begin
                            state_n = AMO_RD;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    mem.re      = core.re;
                    mem.we      = core.we;
                    mem.addr    = core.addr;
                    mem.sel     = core.sel;
                    mem.data_w  = core.data_w;
                    core.ack    = mem.ack;
                    core.data_r = mem.data_r;
                end
            end
            AMO_RD: begin
                mem.re = 1'b1;
                if (mem.ack) begin
                    state_n = (op_r == OP_LR) ? RESP : AMO_WR;
                end else begin
                    state_n = AMO_RD;
                end
            end
            AMO_WR: begin
                mem.we     = 1'b1;
                mem.data_w = amo_alu(op_r, old_r, src_r);
                state_n    = mem.ack ? RESP : AMO_WR;
            end
            SC_WR: begin
                mem.we     = 1'b1;
                mem.data_w = src_r;
                state_n    = mem.ack ? RESP : SC_WR;
            end
            RESP: begin
                core.ack    = 1'b1;
                core.data_r = result_r;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, operand latches, result and the LR/SC reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            addr_r       <= {XLEN{1'b0}};
            src_r        <= {XLEN{1'b0}};
            op_r         <= 5'b00000;
            old_r        <= {XLEN{1'b0}};
            result_r     <= {XLEN{1'b0}};
            resv_valid_r <= 1'b0;
            resv_addr_r  <= {(XLEN-2){1'b0}};
        end else begin
            state_r <= state_n;
            case (state_r)
                IDLE: begin
                    if (atomic_req_s) begin
                        addr_r <= {core.addr[XLEN-1:2], 2'b00};
                        src_r  <= core.data_w;
                        op_r   <= core.amo_op;
                        if (!op_defined(core.amo_op)) begin
                            result_r <= {XLEN{1'b0}};
                        end else if ((core.amo_op == OP_SC) && !sc_hit_s) begin
                            result_r     <= {{(XLEN-1){1'b0}}, 1'b1};
                            resv_valid_r <= 1'b0;
                        end
                    end else if (!core.atomic && core.we && mem.ack && sc_hit_s) begin
                        // A plain store to the reserved word breaks the LR/SC pair.
                        resv_valid_r <= 1'b0;
                    end
                end
                AMO_RD: begin
                    if (mem.ack) begin
                        old_r <= mem.data_r;
                        if (op_r == OP_LR) begin
                            resv_valid_r <= 1'b1;
                            resv_addr_r  <= addr_r[XLEN-1:2];
                            result_r     <= mem.data_r;
                        end
                    end
                end
                AMO_WR: begin
                    if (mem.ack) begin
                        result_r <= old_r;
                    end
                end
                SC_WR: begin
                    if (mem.ack) begin
                        result_r     <= {XLEN{1'b0}};
                        resv_valid_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_c2c_amo_unit.sv
// Directed bench for c2c_amo_unit: a one-wait-state cache model on the mem
// side and an operation-level reference model of memory and reservation.
module tb_c2c_amo_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    c2c_data core_bus ();
    c2c_data mem_bus ();

    c2c_amo_unit dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_bus),
        .mem  (mem_bus)
    );

    int errors = 0;
    int checks = 0;

    // Cache model: acks one cycle after a request appears, one pulse per request.
    logic [31:0] cache_mem [0:255];
    logic        cache_ack;
    logic [31:0] cache_rdata;
    assign mem_bus.ack    = cache_ack;
    assign mem_bus.data_r = cache_rdata;

    always @(posedge clk) begin
        if (rst) begin
            cache_ack <= 1'b0;
        end else if ((mem_bus.re || mem_bus.we) && !cache_ack) begin
            cache_ack <= 1'b1;
            if (mem_bus.we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_bus.sel[b])
                        cache_mem[mem_bus.addr[9:2]][b*8 +: 8] <= mem_bus.data_w[b*8 +: 8];
            end else begin
                cache_rdata <= cache_mem[mem_bus.addr[9:2]];
            end
        end else begin
            cache_ack <= 1'b0;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    bit          ref_resv;
    logic [29:0] ref_resv_word;

    bit pt_active = 1'b0;
    int n_rd = 0;
    int n_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] amo_ref(input logic [4:0] op, input logic [31:0] old,
                                            input logic [31:0] src);
        int so;
        int ss;
        so = old;
        ss = src;
        case (op)
            5'b00001: return src;
            5'b00000: return old + src;
            5'b00100: return old ^ src;
            5'b01100: return old & src;
            5'b01000: return old | src;
            5'b10000: return (so <= ss) ? old : src;
            5'b10100: return (so >= ss) ? old : src;
            5'b11000: return (old <= src) ? old : src;
            5'b11100: return (old >= src) ? old : src;
            default:  return old;
        endcase
    endfunction

    function automatic bit is_alu_op(input logic [4:0] op);
        return op inside {5'b00000, 5'b00001, 5'b00100, 5'b01100, 5'b01000,
                          5'b10000, 5'b10100, 5'b11000, 5'b11100};
    endfunction

    // Operation-level model: result, memory effect, access counts and latency.
    task automatic model_req(input bit is_we, input bit is_atomic, input logic [4:0] op,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] exp_data, output bit chk_data,
                             output int exp_rd, output int exp_wr, output int exp_lat);
        logic [7:0]  idx;
        logic [29:0] word;
        idx      = addr[9:2];
        word     = addr[31:2];
        exp_data = 32'h0;
        chk_data = 1'b1;
        exp_rd   = 0;
        exp_wr   = 0;
        if (!is_atomic) begin
            exp_lat = 1;
            if (is_we) begin
                exp_wr   = 1;
                chk_data = 1'b0;
                ref_mem[idx] = wdata;
                if (ref_resv && ref_resv_word == word) ref_resv = 1'b0;
            end else begin
                exp_rd   = 1;
                exp_data = ref_mem[idx];
            end
        end else begin
            if (op == 5'b00010) begin
                exp_rd        = 1;
                exp_data      = ref_mem[idx];
                ref_resv      = 1'b1;
                ref_resv_word = word;
            end else if (op == 5'b00011) begin
                if (ref_resv && ref_resv_word == word) begin
                    exp_wr       = 1;
                    exp_data     = 32'h0;
                    ref_mem[idx] = wdata;
                end else begin
                    exp_data = 32'h1;
                end
                ref_resv = 1'b0;
            end else if (is_alu_op(op)) begin
                exp_rd       = 1;
                exp_wr       = 1;
                exp_data     = ref_mem[idx];
                ref_mem[idx] = amo_ref(op, ref_mem[idx], wdata);
            end
            exp_lat = 1 + 2 * (exp_rd + exp_wr);
        end
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        cache_mem[addr[9:2]] = val;
        ref_mem[addr[9:2]]   = val;
    endtask

    task automatic do_req(input string name, input bit is_we, input bit is_atomic,
                          input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        logic [31:0] exp_data;
        bit          chk_data;
        int          exp_rd;
        int          exp_wr;
        int          exp_lat;
        bit          got;
        model_req(is_we, is_atomic, op, addr, wdata, exp_data, chk_data, exp_rd, exp_wr, exp_lat);
        @(posedge clk);
        #1;
        n_rd = 0;
        n_wr = 0;
        core_bus.re     = !is_we;
        core_bus.we     = is_we;
        core_bus.addr   = addr;
        core_bus.sel    = 4'hF;
        core_bus.data_w = wdata;
        core_bus.atomic = is_atomic;
        core_bus.amo_op = op;
        pt_active       = !is_atomic;
        lat   = 0;
        got   = 1'b0;
        rdata = 32'h0;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (core_bus.ack) begin
                got   = 1'b1;
                rdata = core_bus.data_r;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!got) begin
            check({name, " ack_timeout"}, 32'd0, 32'd1);
        end else begin
            if (chk_data) check({name, " data"}, rdata, exp_data);
            check({name, " latency"}, lat, exp_lat);
        end
        @(posedge clk);
        #1;
        core_bus.re     = 1'b0;
        core_bus.we     = 1'b0;
        core_bus.atomic = 1'b0;
        core_bus.amo_op = 5'b00000;
        pt_active       = 1'b0;
        @(negedge clk);
        check({name, " single_ack"}, core_bus.ack, 1'b0);
        check({name, " reads"}, n_rd, exp_rd);
        check({name, " writes"}, n_wr, exp_wr);
        check({name, " mem_word"}, cache_mem[addr[9:2]], ref_mem[addr[9:2]]);
    endtask

    // Per-cycle compare: fixed mem fields, pass-through equivalence, access counts.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_bus.ack && mem_bus.re) n_rd++;
            if (mem_bus.ack && mem_bus.we) n_wr++;
            check("mem_atomic", mem_bus.atomic, 1'b0);
            check("mem_amo_op", mem_bus.amo_op, 5'b00000);
            if (pt_active) begin
                check("pt_re", mem_bus.re, core_bus.re);
                check("pt_we", mem_bus.we, core_bus.we);
                check("pt_addr", mem_bus.addr, core_bus.addr);
                check("pt_sel", mem_bus.sel, core_bus.sel);
                check("pt_wdata", mem_bus.data_w, core_bus.data_w);
                check("pt_ack", core_bus.ack, mem_bus.ack);
                if (mem_bus.ack) check("pt_rdata", core_bus.data_r, mem_bus.data_r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] rd;
    int          lat;
    bit          saw;

    initial begin
        rst             = 1'b1;
        core_bus.re     = 1'b0;
        core_bus.we     = 1'b0;
        core_bus.addr   = 32'h0;
        core_bus.sel    = 4'h0;
        core_bus.data_w = 32'h0;
        core_bus.atomic = 1'b0;
        core_bus.amo_op = 5'b00000;
        ref_resv        = 1'b0;
        ref_resv_word   = 30'h0;
        for (int i = 0; i < 256; i++) set_word(32'(i * 4), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset core_ack", core_bus.ack, 1'b0);
        check("reset mem_re", mem_bus.re, 1'b0);
        check("reset mem_we", mem_bus.we, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // AMOADD: 5 + 3, old value returned, ack 5 cycles after request.
        set_word(32'h100, 32'd5);
        do_req("amoadd", 1'b1, 1'b1, 5'b00000, 32'h100, 32'd3, rd, lat);
        check("amoadd lit_data", rd, 32'd5);
        check("amoadd lit_mem", cache_mem[8'h40], 32'd8);
        check("amoadd lit_lat", lat, 32'd5);
        do_req("pt_load", 1'b0, 1'b0, 5'b00000, 32'h100, 32'h0, rd, lat);
        check("pt_load lit", rd, 32'd8);

        // LR/SC success, then a repeat SC fails without writing.
        set_word(32'h200, 32'hAA);
        do_req("lr1", 1'b0, 1'b1, 5'b00010, 32'h200, 32'h0, rd, lat);
        check("lr1 lit", rd, 32'hAA);
        do_req("sc_ok", 1'b1, 1'b1, 5'b00011, 32'h200, 32'h55, rd, lat);
        check("sc_ok lit", rd, 32'd0);
        check("sc_ok lit_mem", cache_mem[8'h80], 32'h55);
        do_req("sc_again", 1'b1, 1'b1, 5'b00011, 32'h200, 32'h66, rd, lat);
        check("sc_again lit", rd, 32'd1);

        // A plain store to the reserved word kills the reservation.
        do_req("lr2", 1'b0, 1'b1, 5'b00010, 32'h200, 32'h0, rd, lat);
        do_req("pt_store", 1'b1, 1'b0, 5'b00000, 32'h200, 32'd7, rd, lat);
        check("pt_store lit_lat", lat, 32'd1);
        do_req("sc_inval", 1'b1, 1'b1, 5'b00011, 32'h200, 32'd9, rd, lat);
        check("sc_inval lit", rd, 32'd1);
        check("sc_inval lit_mem", cache_mem[8'h80], 32'd7);

        // Signed vs unsigned minimum.
        set_word(32'h180, 32'hFFFF_FFFF);
        do_req("amomin", 1'b1, 1'b1, 5'b10000, 32'h180, 32'd1, rd, lat);
        check("amomin lit_mem", cache_mem[8'h60], 32'hFFFF_FFFF);
        do_req("amominu", 1'b1, 1'b1, 5'b11000, 32'h180, 32'd1, rd, lat);
        check("amominu lit", rd, 32'hFFFF_FFFF);
        check("amominu lit_mem", cache_mem[8'h60], 32'd1);

        // Remaining ALU ops.
        set_word(32'h184, 32'h0F0F_0000);
        do_req("amoxor", 1'b1, 1'b1, 5'b00100, 32'h184, 32'h00FF_00FF, rd, lat);
        check("amoxor lit_mem", cache_mem[8'h61], 32'h0FF0_00FF);
        do_req("amoand", 1'b1, 1'b1, 5'b01100, 32'h184, 32'hFF00_FF00, rd, lat);
        do_req("amoor", 1'b1, 1'b1, 5'b01000, 32'h184, 32'h0000_0011, rd, lat);
        do_req("amomax", 1'b1, 1'b1, 5'b10100, 32'h184, 32'h8000_0000, rd, lat);
        do_req("amomaxu", 1'b1, 1'b1, 5'b11100, 32'h184, 32'h8000_0000, rd, lat);
        check("amomaxu lit_mem", cache_mem[8'h61], 32'h8000_0000);

        // Unaligned AMOSWAP and an undefined op.
        do_req("amoswap", 1'b1, 1'b1, 5'b00001, 32'h103, 32'h1234, rd, lat);
        check("amoswap lit", rd, 32'd8);
        check("amoswap lit_mem", cache_mem[8'h40], 32'h1234);
        do_req("undef", 1'b1, 1'b1, 5'b11111, 32'h100, 32'h5555, rd, lat);
        check("undef lit", rd, 32'd0);

        // SC to another word fails and still drops the reservation.
        do_req("lr3", 1'b0, 1'b1, 5'b00010, 32'h200, 32'h0, rd, lat);
        do_req("sc_other", 1'b1, 1'b1, 5'b00011, 32'h204, 32'd3, rd, lat);
        do_req("sc_after", 1'b1, 1'b1, 5'b00011, 32'h200, 32'd4, rd, lat);
        check("sc_after lit", rd, 32'd1);

        // Reset during AMO_WR aborts the sequence and the reservation.
        set_word(32'h300, 32'h10);
        do_req("lr4", 1'b0, 1'b1, 5'b00010, 32'h300, 32'h0, rd, lat);
        @(posedge clk);
        #1;
        core_bus.re     = 1'b0;
        core_bus.we     = 1'b1;
        core_bus.addr   = 32'h300;
        core_bus.data_w = 32'd1;
        core_bus.atomic = 1'b1;
        core_bus.amo_op = 5'b00000;
        saw = 1'b0;
        for (int i = 0; i < 20 && !saw; i++) begin
            @(negedge clk);
            if (mem_bus.we) saw = 1'b1;
        end
        check("rst_mid saw_we", saw, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        core_bus.we     = 1'b0;
        core_bus.atomic = 1'b0;
        @(negedge clk);
        check("rst_mid mem_we", mem_bus.we, 1'b0);
        check("rst_mid core_ack", core_bus.ack, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        ref_resv = 1'b0;
        ref_mem[8'hC0] = cache_mem[8'hC0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid no_ack", core_bus.ack, 1'b0);
        end
        do_req("sc_post_rst", 1'b1, 1'b1, 5'b00011, 32'h300, 32'd5, rd, lat);
        check("sc_post_rst lit", rd, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
